// File: rtl/address_map_decoder_if.sv
// CPU data-port view of the address map decoder: access address and qualifiers in,
// decode results and error-status registers out.
interface address_map_decoder_if;
    logic [31:0] input_addr;
    logic        acc_en;
    logic        err_clr;
    logic [2:0]  select;
    logic [5:0]  control_signals;
    logic        out_of_range_error;
    logic        err_sticky;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    modport master (
        output input_addr, acc_en, err_clr,
        input  select, control_signals, out_of_range_error,
        input  err_sticky, err_addr, err_count
    );

    modport slave (
        input  input_addr, acc_en, err_clr,
        output select, control_signals, out_of_range_error,
        output err_sticky, err_addr, err_count
    );
endinterface

// File: rtl/address_map_decoder.sv
// Fixed MIPS SoC memory-map decoder (DM, INTC, FACT0-3) with a clocked
// out-of-range error-status block for debug polling.
module address_map_decoder (
    input  logic                 clk,
    input  logic                 rst_n,
    address_map_decoder_if.slave bus
);
    logic [2:0]  w_select;
    logic [5:0]  w_ctrl;
    logic        w_oor;
    logic        w_log;
    logic        r_sticky;
    logic [31:0] r_addr;
    logic [7:0]  r_count;

    // Below 0x2000 the map is DM for bit 12 clear, otherwise 256-byte pages by addr[11:8].
    always_comb begin
        w_select = 3'd0;
        w_ctrl   = 6'b000000;
        w_oor    = 1'b1;
        if (bus.input_addr[31:13] == 19'd0) begin
            if (!bus.input_addr[12]) begin
                w_select = 3'd0;
                w_ctrl   = 6'b000001;
                w_oor    = 1'b0;
            end else begin
                case (bus.input_addr[11:8])
                    4'h0: begin w_select = 3'd1; w_ctrl = 6'b000010; w_oor = 1'b0; end
                    4'h1: begin w_select = 3'd2; w_ctrl = 6'b000100; w_oor = 1'b0; end
                    4'h2: begin w_select = 3'd3; w_ctrl = 6'b001000; w_oor = 1'b0; end
                    4'h3: begin w_select = 3'd4; w_ctrl = 6'b010000; w_oor = 1'b0; end
                    4'h4: begin w_select = 3'd5; w_ctrl = 6'b100000; w_oor = 1'b0; end
                    default: begin
                        w_select = 3'd0;
                        w_ctrl   = 6'b000000;
                        w_oor    = 1'b1;
                    end
                endcase
            end
        end
    end

    assign w_log = bus.acc_en & w_oor;

    // A clear coinciding with a logged access restarts the record at that access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_addr   <= 32'd0;
            r_count  <= 8'd0;
        end else if (w_log) begin
            if (!r_sticky || bus.err_clr) begin
                r_sticky <= 1'b1;
                r_addr   <= bus.input_addr;
                r_count  <= 8'd1;
            end else if (r_count != 8'hFF) begin
                r_count  <= r_count + 8'd1;
            end
        end else if (bus.err_clr) begin
            r_sticky <= 1'b0;
            r_addr   <= 32'd0;
            r_count  <= 8'd0;
        end
    end

    assign bus.select             = w_select;
    assign bus.control_signals    = w_ctrl;
    assign bus.out_of_range_error = w_oor;
    assign bus.err_sticky         = r_sticky;
    assign bus.err_addr           = r_addr;
    assign bus.err_count          = r_count;
endmodule

// File: tb/tb_address_map_decoder.sv
// Self-checking bench for address_map_decoder: directed map/error-block steps
// followed by random traffic, compared against a range-based reference model.
module tb_address_map_decoder;
    logic clk;
    logic rst_n;

    address_map_decoder_if bus ();

    address_map_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFails   = 0;

    int          mSticky;
    logic [31:0] mAddr;
    int          mCount;

    // Device index from plain address ranges: 0 = DM, 1..5 = INTC, FACT0..3, -1 = none.
    function automatic int refDevice(input logic [31:0] addr);
        if (addr < 32'h0000_1000) return 0;
        if (addr < 32'h0000_1500) return int'((addr - 32'h0000_1000) / 32'h100) + 1;
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One cycle: drive at the falling edge, check decode, then check registers after the rising edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic acc,
                                 input logic clr, input logic rstn);
        int          dev;
        logic [31:0] eSel;
        logic [31:0] eCtrl;
        logic [31:0] eOor;
        @(negedge clk);
        bus.input_addr = addr;
        bus.acc_en     = acc;
        bus.err_clr    = clr;
        rst_n          = rstn;
        #1;
        dev   = refDevice(addr);
        eSel  = (dev < 0) ? 32'd0 : 32'(dev);
        eCtrl = (dev < 0) ? 32'd0 : (32'd1 << dev);
        eOor  = (dev < 0) ? 32'd1 : 32'd0;
        checkOutput("select", 32'(bus.select), eSel);
        checkOutput("control_signals", 32'(bus.control_signals), eCtrl);
        checkOutput("out_of_range_error", 32'(bus.out_of_range_error), eOor);

        if (!rstn) begin
            mSticky = 0; mAddr = 32'd0; mCount = 0;
        end else if (acc && dev < 0) begin
            if (mSticky == 0 || clr) begin
                mSticky = 1; mAddr = addr; mCount = 1;
            end else begin
                mCount = (mCount >= 255) ? 255 : mCount + 1;
            end
        end else if (clr) begin
            mSticky = 0; mAddr = 32'd0; mCount = 0;
        end

        @(posedge clk);
        #1;
        checkOutput("err_sticky", 32'(bus.err_sticky), 32'(mSticky));
        checkOutput("err_addr", bus.err_addr, mAddr);
        checkOutput("err_count", 32'(bus.err_count), 32'(mCount));
    endtask

    logic [31:0] sweep [10];
    logic [31:0] bad   [5];

    initial begin
        logic [31:0] a;
        mSticky = 0; mAddr = 32'd0; mCount = 0;
        bus.input_addr = 32'd0; bus.acc_en = 1'b0; bus.err_clr = 1'b0; rst_n = 1'b0;

        $display("[TB] reset");
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] region boundary sweep");
        sweep = '{32'h0, 32'hFFC, 32'h1000, 32'h10FC, 32'h1100,
                  32'h11FC, 32'h1200, 32'h1300, 32'h1400, 32'h14FC};
        foreach (sweep[i]) applyStimulus(sweep[i], 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h0000_0FFF, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h0000_14FF, 1'b1, 1'b0, 1'b1);

        $display("[TB] out-of-range without access");
        bad = '{32'h1500, 32'h1FFC, 32'h2000, 32'h8000_0000, 32'hFFFF_FFFF};
        foreach (bad[i]) applyStimulus(bad[i], 1'b0, 1'b0, 1'b1);

        $display("[TB] first-error capture");
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h2000, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h3000, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h1234, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h0000_1500, 1'b0, 1'b0, 1'b1);

        $display("[TB] clear behaviour");
        applyStimulus(32'h100, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'h5000, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h4000, 1'b1, 1'b1, 1'b1);
        applyStimulus(32'h6000, 1'b1, 1'b0, 1'b1);

        $display("[TB] saturation and mid-stream reset");
        for (int i = 0; i < 310; i++) begin
            a = 32'h0000_2000 + (32'(i) << 2);
            applyStimulus(a, 1'b1, 1'b0, (i == 303) ? 1'b0 : 1'b1);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       a = $urandom;
                1:       a = $urandom_range(0, 32'h1FFF);
                default: a = $urandom_range(32'h0FF0, 32'h1510);
            endcase
            applyStimulus(a, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 49) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
